// File: rtl/bus_responder.sv
// Memory-side responder for the 64-bit tagged request/response bus.
// Accepts single-beat address requests, then wrapping write data bursts or returns wrapping read bursts.
module bus_responder #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int MEM_ADDR_BITS  = 12,
    parameter int BURST_LEN      = 8,
    parameter int READ_LATENCY   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bus_reqcyc,
    output logic                      bus_reqack,
    input  logic [BUS_DATA_WIDTH-1:0] bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    output logic                      bus_respcyc,
    input  logic                      bus_respack,
    output logic [BUS_DATA_WIDTH-1:0] bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  bus_resptag
);

    localparam int BEAT_W = $clog2(BURST_LEN);
    localparam int LINE_W = MEM_ADDR_BITS - BEAT_W;
    localparam int LAT_W  = $clog2(READ_LATENCY + 1);
    localparam int DEPTH  = 1 << MEM_ADDR_BITS;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [BEAT_W-1:0] ONE_BEAT  = BEAT_W'(1);
    localparam logic [LAT_W-1:0]  LAT_INIT  = LAT_W'(READ_LATENCY - 1);
    localparam logic [LAT_W-1:0]  ONE_LAT   = LAT_W'(1);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_WR_DATA  = 2'd1;
    localparam logic [1:0] S_RD_WAIT  = 2'd2;
    localparam logic [1:0] S_RD_BURST = 2'd3;

    logic [1:0]                r_state;
    logic [LINE_W-1:0]         r_line;
    logic [BEAT_W-1:0]         r_off;
    logic [BEAT_W-1:0]         r_beat;
    logic [LAT_W-1:0]          r_lat;
    logic [BUS_TAG_WIDTH-1:0]  r_tag;
    logic                      r_respcyc;
    logic [BUS_DATA_WIDTH-1:0] r_resp;
    logic [BUS_TAG_WIDTH-1:0]  r_resptag;
    logic [BUS_DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [MEM_ADDR_BITS-1:0] w_word;
    logic                     w_accept;
    logic [BEAT_W-1:0]        w_wr_slot;
    logic [BEAT_W-1:0]        w_rd_beat;
    logic [BEAT_W-1:0]        w_rd_slot;
    logic [MEM_ADDR_BITS-1:0] w_wr_idx;
    logic [MEM_ADDR_BITS-1:0] w_rd_idx;
    logic                     w_unused;

    // Byte offset and bits above the RAM size are dropped, so addresses alias.
    assign w_word   = bus_req[MEM_ADDR_BITS+2:3];
    assign w_unused = ^{bus_req[BUS_DATA_WIDTH-1:MEM_ADDR_BITS+3], bus_req[2:0]};

    assign bus_reqack = bus_reqcyc && !reset && (r_state == S_IDLE || r_state == S_WR_DATA);
    assign w_accept   = bus_reqcyc && bus_reqack;

    // Slot arithmetic wraps inside the line; the line index itself never moves.
    assign w_wr_slot = r_off + r_beat;
    assign w_rd_beat = (r_state == S_RD_WAIT) ? '0 : r_beat + ONE_BEAT;
    assign w_rd_slot = r_off + w_rd_beat;
    assign w_wr_idx  = {r_line, w_wr_slot};
    assign w_rd_idx  = {r_line, w_rd_slot};

    assign bus_respcyc = r_respcyc;
    assign bus_resp    = r_resp;
    assign bus_resptag = r_resptag;

    always_ff @(posedge clk) begin
        if (r_state == S_WR_DATA && w_accept) begin
            r_mem[w_wr_idx] <= bus_req;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_line    <= '0;
            r_off     <= '0;
            r_beat    <= '0;
            r_lat     <= '0;
            r_tag     <= '0;
            r_respcyc <= 1'b0;
            r_resp    <= '0;
            r_resptag <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_line <= w_word[MEM_ADDR_BITS-1:BEAT_W];
                        r_off  <= w_word[BEAT_W-1:0];
                        r_tag  <= bus_reqtag;
                        r_beat <= '0;
                        if (bus_reqtag[BUS_TAG_WIDTH-1]) begin
                            r_state <= S_WR_DATA;
                        end else begin
                            r_state <= S_RD_WAIT;
                            r_lat   <= LAT_INIT;
                        end
                    end
                end
                S_WR_DATA: begin
                    if (w_accept) begin
                        r_beat <= r_beat + ONE_BEAT;
                        if (r_beat == LAST_BEAT) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_RD_WAIT: begin
                    if (r_lat == '0) begin
                        r_state   <= S_RD_BURST;
                        r_beat    <= '0;
                        r_respcyc <= 1'b1;
                        r_resp    <= r_mem[w_rd_idx];
                        r_resptag <= r_tag;
                    end else begin
                        r_lat <= r_lat - ONE_LAT;
                    end
                end
                S_RD_BURST: begin
                    // Outputs are held until the requester takes the beat.
                    if (bus_respack) begin
                        if (r_beat == LAST_BEAT) begin
                            r_state   <= S_IDLE;
                            r_respcyc <= 1'b0;
                        end else begin
                            r_beat <= r_beat + ONE_BEAT;
                            r_resp <= r_mem[w_rd_idx];
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
